// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_ctrl_pkg;

  // Width of one hex digit and of the segment bus.
  localparam int NIB_W = 4;
  localparam int SEG_W = 7;

  typedef logic [NIB_W-1:0] nibble_t;
  typedef logic [SEG_W-1:0] seg_t;

  // Segment pattern with every segment dark (segments are active-low, gfedcba).
  localparam seg_t SEG_OFF = 7'h7F;

  // Decimal point dark level (active-low).
  localparam logic DP_OFF = 1'b1;

endpackage

// File: rtl/seg_scan_ctrl_dec.sv
// Hex digit to 7-segment decoder, gfedcba order, active-low segments.
module seg_scan_ctrl_dec
  import seg_scan_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] i_nib,
  output logic [SEG_W-1:0] o_seg
);

  // Pure lookup: one shared decoder serves whichever digit is being scanned.
  always_comb begin
    o_seg = SEG_OFF;
    case (i_nib)
      4'h0:    o_seg = 7'h40;
      4'h1:    o_seg = 7'h79;
      4'h2:    o_seg = 7'h24;
      4'h3:    o_seg = 7'h30;
      4'h4:    o_seg = 7'h19;
      4'h5:    o_seg = 7'h12;
      4'h6:    o_seg = 7'h02;
      4'h7:    o_seg = 7'h78;
      4'h8:    o_seg = 7'h00;
      4'h9:    o_seg = 7'h10;
      4'hA:    o_seg = 7'h08;
      4'hB:    o_seg = 7'h03;
      4'hC:    o_seg = 7'h46;
      4'hD:    o_seg = 7'h21;
      4'hE:    o_seg = 7'h06;
      4'hF:    o_seg = 7'h0E;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// A new value is staged in a pending register and only copied into the display
// register when the digit index wraps, so a frame never mixes two values.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_load_valid,
  output logic                        o_load_ready,
  input  logic [NIB_W*NUM_DIGITS-1:0] i_value_in,
  input  logic [NUM_DIGITS-1:0]       i_dp_in,
  input  logic                        i_blank_lz,
  output logic [NUM_DIGITS-1:0]       o_an,
  output logic [SEG_W-1:0]            o_seg,
  output logic                        o_dp,
  output logic                        o_frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = $clog2(REFRESH_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Anode pattern with every digit off; XOR with a one-hot select gives the
  // driven pattern for either polarity.
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                               : {NUM_DIGITS{1'b0}};

  // Scan position
  logic [DIV_W-1:0] r_div_cnt;
  logic [IDX_W-1:0] r_idx;

  // Handshake / display storage
  logic [NIB_W*NUM_DIGITS-1:0] r_pend;
  logic [NUM_DIGITS-1:0]       r_pend_dp;
  logic                        r_pend_full;
  logic [NIB_W*NUM_DIGITS-1:0] r_disp;
  logic [NUM_DIGITS-1:0]       r_disp_dp;

  // Registered pin drivers
  logic [NUM_DIGITS-1:0] r_an;
  logic [SEG_W-1:0]      r_seg;
  logic                  r_dp;
  logic                  r_frame_tick;

  // Combinational helpers
  logic                  w_term;
  logic                  w_wrap;
  logic                  w_accept;
  logic [NUM_DIGITS-1:0] w_lz_mask;
  logic                  w_upper_zero;
  logic [NIB_W-1:0]      w_nib;
  logic                  w_dig_dp;
  logic                  w_sel_lz;
  logic [NUM_DIGITS-1:0] w_an_hot;
  logic                  w_slot_active;
  logic                  w_show;
  logic [SEG_W-1:0]      w_dec_seg;

  // Terminal count of a slot, and the last slot of a frame.
  assign w_term   = (r_div_cnt == DIV_LAST);
  assign w_wrap   = w_term && (r_idx == IDX_LAST);
  assign w_accept = i_load_valid && !r_pend_full;

  assign o_load_ready = ~r_pend_full;

  // Slot divider and digit index; the index advances once per slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (w_term) begin
      r_div_cnt <= '0;
      r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Frame pulse: high for the single cycle after the index wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_wrap;
    end
  end

  // Pending slot accepts one value; it is promoted to the display only on a wrap.
  // An accept landing on the wrap itself sees pend_full=0, so it waits a frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend      <= '0;
      r_pend_dp   <= '0;
      r_pend_full <= 1'b0;
      r_disp      <= '0;
      r_disp_dp   <= '0;
    end else begin
      if (w_wrap && r_pend_full) begin
        r_disp    <= r_pend;
        r_disp_dp <= r_pend_dp;
      end
      if (w_accept) begin
        r_pend    <= i_value_in;
        r_pend_dp <= i_dp_in;
      end
      if (w_accept) begin
        r_pend_full <= 1'b1;
      end else if (w_wrap) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  // Leading-zero mask: bit i set when displayed nibbles i..top are all zero.
  // Digit 0 is never part of the mask so a zero value still shows "0".
  always_comb begin
    w_upper_zero = 1'b1;
    w_lz_mask    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_upper_zero = w_upper_zero & (r_disp[NIB_W*i +: NIB_W] == 4'h0);
      w_lz_mask[i] = w_upper_zero;
    end
  end

  // Select the scanned digit's nibble, decimal point and blanking flag.
  always_comb begin
    w_nib    = '0;
    w_dig_dp = 1'b0;
    w_sel_lz = 1'b0;
    w_an_hot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_disp[NIB_W*i +: NIB_W];
        w_dig_dp    = r_disp_dp[i];
        w_sel_lz    = w_lz_mask[i];
        w_an_hot[i] = 1'b1;
      end
    end
  end

  // The first BLANK_CYC cycles of a slot stay dark so the previous digit's
  // segments cannot ghost onto the newly enabled anode.
  assign w_slot_active = (r_div_cnt >= BLANK_END);
  assign w_show        = w_slot_active && !(i_blank_lz && w_sel_lz);

  seg_scan_ctrl_dec u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec_seg)
  );

  // Register the pin drivers so anodes, segments and dp switch together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
    end else if (w_show) begin
      r_an  <= w_an_hot ^ AN_OFF;
      r_seg <= w_dec_seg;
      r_dp  <= ~w_dig_dp;
    end else begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
    end
  end

  assign o_an         = r_an;
  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, 8 cycles per slot, 2 blank cycles).
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC),
    .AN_ACT_LOW  (1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_load_valid (load_valid),
    .o_load_ready (load_ready),
    .i_value_in   (value_in),
    .i_dp_in      (dp_in),
    .i_blank_lz   (blank_lz),
    .o_an         (an),
    .o_seg        (seg),
    .o_dp         (dp),
    .o_frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         frame;
    int         slot;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;

  int errors = 0;
  int checks = 0;

  // Monitor state
  int         mon_frame = 0;
  int         mon_pos = -1;
  int         cyc = 0;
  int         last_tick = 0;
  bit         in_rst = 1'b1;
  logic [3:0] s_an;
  logic [6:0] s_seg;
  logic       s_dp;
  bit         s_blank_ok;
  bit         s_steady;
  bit         s_ghost;
  int         m_slot;
  int         m_off;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Hand-written frame expectation: segs = {slot3,slot2,slot1,slot0}, dpn = dp pin per slot,
  // shown bit clear = digit blanked by leading-zero suppression.
  task automatic push_frame(input int f, input logic [27:0] segs, input logic [3:0] dpn,
                            input logic [3:0] shown);
    exp_t e;
    for (int s = 0; s < ND; s++) begin
      e.frame = f;
      e.slot  = s;
      if (shown[s]) begin
        e.an  = ~(4'b0001 << s);
        e.seg = segs[7*s +: 7];
        e.dp  = dpn[s];
      end else begin
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
      end
      sb_q.push_back(e);
    end
  endtask

  // Returns just after the clock edge following a frame_tick, with that frame's number.
  task automatic wait_tick(output int f);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 100);
    if (!frame_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no frame_tick, required one within 100 cycles");
    end
    @(posedge clk);
    #1;
    f = mon_frame;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, output int n);
    logic rdy;
    value_in   = v;
    dp_in      = d;
    load_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = load_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    #1;
    load_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got ready=0 for 200 cycles, required accept");
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d expectations left, required 0", sb_q.size());
    end
  endtask

  // Monitor: slices output into frames/slots using frame_tick and scores each slot.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mon_pos   = -1;
      mon_frame = 0;
      in_rst    = 1'b1;
    end else begin
      if (in_rst) begin
        last_tick = cyc;
        in_rst    = 1'b0;
      end
      if (mon_pos >= 0 && mon_pos < FRAME) begin
        m_slot = mon_pos / RD;
        m_off  = mon_pos % RD;
        if (m_off == 0) begin
          s_blank_ok = 1'b1;
          s_steady   = 1'b1;
          s_ghost    = 1'b0;
        end
        if (m_off < BC && an !== 4'hF) s_blank_ok = 1'b0;
        if ($countones(~an) > 1) s_ghost = 1'b1;
        if (m_off == BC) begin
          s_an  = an;
          s_seg = seg;
          s_dp  = dp;
        end else if (m_off > BC && (an !== s_an || seg !== s_seg || dp !== s_dp)) begin
          s_steady = 1'b0;
        end
        if (m_off == RD - 1) begin
          checks++;
          if (!s_blank_ok || s_ghost) begin
            errors++;
            $display("FAIL slot_blank f%0d s%0d: got blank_ok=%0d ghost=%0d, required blank_ok=1 ghost=0",
                     mon_frame, m_slot, s_blank_ok, s_ghost);
          end
          while (sb_q.size() > 0 && (sb_q[0].frame < mon_frame ||
                 (sb_q[0].frame == mon_frame && sb_q[0].slot < m_slot))) begin
            checks++;
            errors++;
            $display("FAIL missed_slot: got no slot f%0d s%0d, required it before f%0d s%0d",
                     sb_q[0].frame, sb_q[0].slot, mon_frame, m_slot);
            void'(sb_q.pop_front());
          end
          if (sb_q.size() > 0 && sb_q[0].frame == mon_frame && sb_q[0].slot == m_slot) begin
            m_e = sb_q.pop_front();
            checks++;
            if (!s_steady || s_an !== m_e.an || s_seg !== m_e.seg || s_dp !== m_e.dp) begin
              errors++;
              $display("FAIL slot f%0d s%0d: got an=%b seg=%b dp=%b steady=%0d, required an=%b seg=%b dp=%b steady=1",
                       mon_frame, m_slot, s_an, s_seg, s_dp, s_steady, m_e.an, m_e.seg, m_e.dp);
            end
          end
        end
        mon_pos++;
      end
      if (frame_tick) begin
        checks++;
        if (cyc - last_tick != FRAME) begin
          errors++;
          $display("FAIL tick_period: got %0d cycles, required %0d", cyc - last_tick, FRAME);
        end
        last_tick = cyc;
        mon_frame++;
        mon_pos = 0;
      end
    end
  end

  initial begin
    int f;
    int n;

    // Power-on reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_ready", load_ready, 1'b1);
    check("rst_tick", frame_tick, 1'b0);
    rst_n = 1'b1;

    // Zero value after reset, all digits shown
    wait_tick(f);
    push_frame(f, {4{7'h40}}, 4'hF, 4'hF);

    // 12AF with dp on digit 1
    do_load(16'h12AF, 4'b0010, n);
    @(negedge clk);
    check("ready_low_after_accept", load_ready, 1'b0);
    push_frame(f + 1, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1101, 4'hF);
    wait_tick(f);
    check("ready_after_wrap", load_ready, 1'b1);

    // Leading-zero blanking of 0005, then live switch-off of blanking
    blank_lz = 1'b1;
    do_load(16'h0005, 4'b0000, n);
    push_frame(f + 1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'hF, 4'b0001);
    wait_tick(f);
    wait_tick(f);
    blank_lz = 1'b0;
    push_frame(f, {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, 4'hF);

    // Back-to-back loads: the second stalls until the first is committed
    do_load(16'h1111, 4'b0000, n);
    check("load1_wait", n, 1);
    push_frame(f + 1, {4{7'h79}}, 4'hF, 4'hF);
    push_frame(f + 2, {4{7'h24}}, 4'b1011, 4'hF);
    do_load(16'h2222, 4'b0100, n);
    check("load2_stall", n, FRAME - 1);

    // Accept exactly on the wrap edge: shows one frame later
    wait_tick(f);
    repeat (FRAME - 2) @(posedge clk);
    #1;
    do_load(16'h9C3E, 4'b1001, n);
    check("wrap_accept_wait", n, 1);
    @(negedge clk);
    check("wrap_accept_tick", frame_tick, 1'b1);
    check("wrap_accept_pending", load_ready, 1'b0);
    push_frame(f + 1, {4{7'h24}}, 4'b1011, 4'hF);
    push_frame(f + 2, {7'h10, 7'h46, 7'h30, 7'h06}, 4'b0110, 4'hF);
    wait_drain();

    // Mid-run reset with a value pending and a digit lit
    wait_tick(f);
    do_load(16'hFFFF, 4'hF, n);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_lit", an, 4'b1110);
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_dp", dp, 1'b1);
    check("mid_rst_ready", load_ready, 1'b1);
    check("mid_rst_tick", frame_tick, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_tick(f);
    push_frame(f, {4{7'h40}}, 4'hF, 4'hF);
    push_frame(f + 1, {4{7'h40}}, 4'hF, 4'hF);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
